// File: rtl/iomem_pkg.sv
// iomem_pkg: shared definitions for the iomem bus sequencer and its decoder.
//   state_t      - sequencer states (IDLE / WAIT / DONE)
//   err_code_t   - sticky error status codes reported on err_code
//   ERR_DATA_DEFAULT - read data returned on any error completion
//   idx_width()  - width of a slave index for a given slave count (min 1)
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_code_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // A single slave still needs a 1-bit index signal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iomem_addr_decode.sv
// iomem_addr_decode: combinational base-byte address decoder.
// Compares the top address byte against each slave's base byte; the lowest
// matching slave index wins.
//   i_addr_hi  in   8     address bits [31:24]
//   o_hit      out  1     some slave matched
//   o_idx      out  IDXW  index of the lowest matching slave (0 when no hit)
module iomem_addr_decode
  import iomem_pkg::*;
#(
  parameter int unsigned       NSLV      = 4,
  parameter logic [NSLV*8-1:0] SLV_BASES = {8'h02, 8'h03, 8'h80, 8'h40}
) (
  input  logic [7:0]                  i_addr_hi,
  output logic                        o_hit,
  output logic [idx_width(NSLV)-1:0]  o_idx
);

  localparam int unsigned IDXW = idx_width(NSLV);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!o_hit && (i_addr_hi == SLV_BASES[8*i +: 8])) begin
        o_hit = 1'b1;
        o_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/iomem_ctrl.sv
// iomem_ctrl: iomem bus sequencer, one master shared among NSLV slaves.
// A request is latched in IDLE and decoded; a hit selects one slave
// (registered, one-hot) and waits for its ready, bounded by TIMEOUT cycles.
// Unmapped or timed-out accesses complete with ERR_DATA and are logged in
// sticky error status so the master never stalls.
//   clk, reset       clock, asynchronous active-high reset
//   m_valid/m_ready  master request / one-cycle completion pulse
//   m_addr/m_wstrb/m_wdata/m_rdata  master address, strobes, data
//   s_sel            one-hot slave select
//   s_ready/s_rdata  per-slave ready and packed read data
//   s_addr/s_wstrb/s_wdata  latched request towards the slaves
//   err_clr          clears sticky error status
//   err_flag/err_code/err_addr  sticky error status (first error since clear)
// Slave i base byte lives at SLV_BASES[8i+:8], so the default maps
// slave 0 -> 8'h40, slave 1 -> 8'h80, slave 2 -> 8'h03, slave 3 -> 8'h02.
module iomem_ctrl
  import iomem_pkg::*;
#(
  parameter int unsigned       NSLV      = 4,
  parameter logic [NSLV*8-1:0] SLV_BASES = {8'h02, 8'h03, 8'h80, 8'h40},
  parameter int unsigned       TIMEOUT   = 1024,
  parameter logic [31:0]       ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [31:0]          m_addr,
  input  logic [3:0]           m_wstrb,
  input  logic [31:0]          m_wdata,
  output logic [31:0]          m_rdata,
  output logic [NSLV-1:0]      s_sel,
  input  logic [NSLV-1:0]      s_ready,
  input  logic [NSLV*32-1:0]   s_rdata,
  output logic [23:0]          s_addr,
  output logic [3:0]           s_wstrb,
  output logic [31:0]          s_wdata,
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [1:0]           err_code,
  output logic [31:0]          err_addr
);

  localparam int unsigned     IDXW     = idx_width(NSLV);
  localparam int unsigned     CNTW     = $clog2(TIMEOUT) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [CNTW-1:0]  r_cnt;
  logic [NSLV-1:0]  r_sel;
  logic [31:0]      r_addr;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err_flag;
  err_code_t        r_err_code;
  logic [31:0]      r_err_addr;

  logic             w_dec_hit;
  logic [IDXW-1:0]  w_dec_idx;
  logic [NSLV-1:0]  w_sel_onehot;
  logic             w_sel_ready;
  logic [31:0]      w_sel_rdata;

  logic             w_latch;
  logic             w_start;
  logic             w_cnt_inc;
  logic             w_capture;
  logic             w_err_evt;
  err_code_t        w_err_kind;
  logic [31:0]      w_err_addr;

  iomem_addr_decode #(
    .NSLV      (NSLV),
    .SLV_BASES (SLV_BASES)
  ) u_dec (
    .i_addr_hi (m_addr[31:24]),
    .o_hit     (w_dec_hit),
    .o_idx     (w_dec_idx)
  );

  // Only the selected slave's ready/data are observed; the one-hot select
  // for the next transaction is built from the decoder index.
  always_comb begin
    w_sel_ready  = 1'b0;
    w_sel_rdata  = '0;
    w_sel_onehot = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[32*i +: 32];
      end
      w_sel_onehot[i] = (w_dec_idx == IDXW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_start     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_capture   = 1'b0;
    w_err_evt   = 1'b0;
    w_err_kind  = ERR_NONE;
    w_err_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) begin
          w_latch = 1'b1;
          if (w_dec_hit) begin
            w_start     = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_err_evt   = 1'b1;
            w_err_kind  = ERR_UNMAPPED;
            w_err_addr  = m_addr;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (w_sel_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_evt   = 1'b1;
          w_err_kind  = ERR_TIMEOUT;
          w_err_addr  = r_addr;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err_flag <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_addr <= '0;
    end else begin
      if (w_latch) begin
        r_addr  <= m_addr;
        r_wstrb <= m_wstrb;
        r_wdata <= m_wdata;
      end

      if (w_start) begin
        r_sel <= w_sel_onehot;
        r_idx <= w_dec_idx;
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_capture || w_err_evt) begin
        r_sel <= '0;
      end

      if (w_capture)      r_rdata <= w_sel_rdata;
      else if (w_err_evt) r_rdata <= ERR_DATA;

      // A new error is logged when status is empty or being cleared in the
      // same cycle (set wins over clear).
      if (w_err_evt && (!r_err_flag || err_clr)) begin
        r_err_flag <= 1'b1;
        r_err_code <= w_err_kind;
        r_err_addr <= w_err_addr;
      end else if (err_clr) begin
        r_err_flag <= 1'b0;
        r_err_code <= ERR_NONE;
        r_err_addr <= '0;
      end
    end
  end

  assign m_ready  = (r_state == ST_DONE);
  assign m_rdata  = r_rdata;
  assign s_sel    = r_sel;
  assign s_addr   = r_addr[23:0];
  assign s_wstrb  = r_wstrb;
  assign s_wdata  = r_wdata;
  assign err_flag = r_err_flag;
  assign err_code = r_err_code;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_iomem_ctrl.sv
// Randomised bench for iomem_ctrl with a transaction-level reference model.
module tb_iomem_ctrl;

  localparam int unsigned NSLV    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] ERRD    = 32'hDEADBEEF;

  logic                clk;
  logic                reset;
  logic                m_valid;
  logic                m_ready;
  logic [31:0]         m_addr;
  logic [3:0]          m_wstrb;
  logic [31:0]         m_wdata;
  logic [31:0]         m_rdata;
  logic [NSLV-1:0]     s_sel;
  logic [NSLV-1:0]     s_ready;
  logic [NSLV*32-1:0]  s_rdata;
  logic [23:0]         s_addr;
  logic [3:0]          s_wstrb;
  logic [31:0]         s_wdata;
  logic                err_clr;
  logic                err_flag;
  logic [1:0]          err_code;
  logic [31:0]         err_addr;

  iomem_ctrl #(
    .NSLV      (NSLV),
    .SLV_BASES ({8'h02, 8'h03, 8'h80, 8'h40}),
    .TIMEOUT   (TIMEOUT),
    .ERR_DATA  (ERRD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_wstrb  (m_wstrb),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .s_sel    (s_sel),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .s_addr   (s_addr),
    .s_wstrb  (s_wstrb),
    .s_wdata  (s_wdata),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_code (err_code),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Slave map as seen by software: slave index -> base byte.
  logic [7:0] base_of [NSLV] = '{8'h40, 8'h80, 8'h03, 8'h02};

  // Reference sticky error status.
  logic        mdl_flag = 1'b0;
  logic [1:0]  mdl_code = 2'b00;
  logic [31:0] mdl_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int find_slave(input logic [31:0] a);
    for (int i = 0; i < int'(NSLV); i++)
      if (a[31:24] == base_of[i]) return i;
    return -1;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".err_flag"}, 32'(err_flag), 32'(mdl_flag));
    check({tag, ".err_code"}, 32'(err_code), 32'(mdl_code));
    check({tag, ".err_addr"}, err_addr, mdl_addr);
  endtask

  // One master access. d = cycles the target slave waits after seeing its
  // select before raising ready; noise = random ready on other slaves;
  // drop = master drops valid during WAIT; clr = err_clr on the completing edge.
  task automatic txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     input logic [31:0] tgt_rd, input int d, input bit noise,
                     input bit drop, input bit clr);
    int              tgt;
    int              lat;
    logic [31:0]     exp_rd;
    logic [NSLV-1:0] oh;
    logic [NSLV-1:0] rnd;
    bit              err_ev;
    logic [1:0]      code;
    logic [31:0]     rd [NSLV];

    tgt    = find_slave(a);
    oh     = '0;
    err_ev = 1'b0;
    code   = 2'b00;
    for (int i = 0; i < int'(NSLV); i++) rd[i] = $urandom;
    if (tgt < 0) begin
      lat = 1; exp_rd = ERRD; err_ev = 1'b1; code = 2'b01;
    end else begin
      rd[tgt] = tgt_rd;
      oh[tgt] = 1'b1;
      if (d <= int'(TIMEOUT) - 1) begin
        lat = d + 2; exp_rd = tgt_rd;
      end else begin
        lat = int'(TIMEOUT) + 1; exp_rd = ERRD; err_ev = 1'b1; code = 2'b10;
      end
    end

    @(negedge clk);
    for (int i = 0; i < int'(NSLV); i++) s_rdata[32*i +: 32] = rd[i];
    m_valid = 1'b1;
    m_addr  = a;
    m_wstrb = ws;
    m_wdata = wd;
    s_ready = '0;
    err_clr = clr && (lat == 1);

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      check("m_ready", 32'(m_ready), 32'(c == lat));
      check("s_sel", 32'(s_sel), 32'((c < lat) ? oh : '0));
      if (tgt >= 0 && c < lat) begin
        check("s_addr", 32'(s_addr), 32'(a[23:0]));
        check("s_wstrb", 32'(s_wstrb), 32'(ws));
        check("s_wdata", s_wdata, wd);
      end
      if (c == lat) begin
        if (err_ev && (!mdl_flag || clr)) begin
          mdl_flag = 1'b1; mdl_code = code; mdl_addr = a;
        end else if (clr) begin
          mdl_flag = 1'b0; mdl_code = 2'b00; mdl_addr = '0;
        end
        check("m_rdata", m_rdata, exp_rd);
        check_status("done");
        m_valid = 1'b0;
      end
      if (c == lat + 1) check("m_rdata.hold", m_rdata, exp_rd);
      if (drop && c == 1) m_valid = 1'b0;
      rnd     = noise ? (NSLV'($urandom) & ~oh) : '0;
      s_ready = rnd | ((tgt >= 0 && c >= d + 1 && c < lat) ? oh : '0);
      err_clr = clr && (c == lat - 1);
    end
    s_ready = '0;
    err_clr = 1'b0;
  endtask

  task automatic clear_status();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mdl_flag = 1'b0; mdl_code = 2'b00; mdl_addr = '0;
    check_status("clr");
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = 32'h4000_0040;
    m_wstrb = 4'b0000;
    s_ready = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.s_sel", 32'(s_sel), 32'h0);
    check("rst.m_ready", 32'(m_ready), 32'h0);
    mdl_flag = 1'b0; mdl_code = 2'b00; mdl_addr = '0;
    check_status("rst");
    m_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst.m_ready", 32'(m_ready), 32'h0);
      check("post_rst.s_sel", 32'(s_sel), 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          d;

    reset   = 1'b1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wstrb = '0;
    m_wdata = '0;
    s_ready = '0;
    s_rdata = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.m_ready", 32'(m_ready), 32'h0);
    check("reset.m_rdata", m_rdata, 32'h0);
    check("reset.s_sel", 32'(s_sel), 32'h0);
    check("reset.s_addr", 32'(s_addr), 32'h0);
    check("reset.s_wstrb", 32'(s_wstrb), 32'h0);
    check("reset.s_wdata", s_wdata, 32'h0);
    check_status("reset");
    reset = 1'b0;

    // Directed scenarios.
    txn(32'h0300_0000, 4'b0000, 32'h0, 32'h0000_00A5, 0, 1'b0, 1'b0, 1'b0);
    txn(32'h8000_0010, 4'b0011, 32'h1234_5678, 32'h0BAD_F00D, 5, 1'b0, 1'b0, 1'b0);
    txn(32'h1000_0000, 4'b0000, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    clear_status();
    txn(32'h4000_0000, 4'b0000, 32'h0, 32'h0, 100, 1'b0, 1'b0, 1'b0);
    txn(32'h4000_0100, 4'b1111, 32'hCAFE_0001, 32'h0, 100, 1'b0, 1'b0, 1'b0);
    clear_status();
    txn(32'h4000_0200, 4'b0000, 32'h0, 32'h7777_0001, int'(TIMEOUT) - 1, 1'b0, 1'b0, 1'b0);
    reset_mid_wait();
    txn(32'h0300_0004, 4'b0000, 32'h0, 32'h5A5A_1234, 1, 1'b0, 1'b0, 1'b0);
    txn(32'h2000_0000, 4'b0000, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    txn(32'h5500_0008, 4'b0000, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
    txn(32'h0200_0020, 4'b0000, 32'h0, 32'h3141_5926, 3, 1'b1, 1'b0, 1'b0);
    txn(32'h8000_0030, 4'b0000, 32'h0, 32'h2718_2818, 2, 1'b1, 1'b1, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:24] = base_of[$urandom_range(0, NSLV - 1)];
      if ($urandom_range(0, 6) != 0) d = $urandom_range(0, 6);
      else                           d = $urandom_range(TIMEOUT - 2, TIMEOUT + 3);
      txn(a, 4'($urandom), $urandom, $urandom, d, 1'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 11) == 0) clear_status();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
